accu_sched: RTL and testbench

- Round-robin scheduler that shares one accu accumulator datapath between NREQ requesters.
- Each requester submits a job of `len` operands. The block grants the accumulator, clears it, streams the owner's operands into it, then returns the registered sum with a one-cycle done pulse.
- Sits between requester logic and a single accu instance. It drives the accumulator's operand and clear inputs and reads its output.
- Accumulator model: on every rising clk, acc_out <= acc_clr ? 0 : acc_out + acc_in.

---
 rtl/accu_sched_pkg.sv | 16 +
 rtl/accu_sched_if.sv | 30 +++
 rtl/accu_sched_rr_arbiter.sv | 32 +++
 rtl/accu_sched.sv | 114 +++++++++++
 tb/tb_accu_sched.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/accu_sched_pkg.sv
// Shared types and default sizes for the accu_sched scheduler and its accu datapath.
package accu_sched_pkg;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_LENW  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/accu_sched_if.sv
// Requester-side bundle of accu_sched: job requests, operand streams and job results.
interface accu_sched_if
  import accu_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENW  = DEF_LENW
);

  logic [NREQ-1:0]       req;
  logic [NREQ*LENW-1:0]  len;
  logic [NREQ*WIDTH-1:0] opd;
  logic [NREQ-1:0]       opd_vld;
  logic [NREQ-1:0]       pop;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  busy;

  modport master (
    output req, len, opd, opd_vld,
    input  pop, gnt, done, result, busy
  );

  modport slave (
    input  req, len, opd, opd_vld,
    output pop, gnt, done, result, busy
  );

endinterface

// File: rtl/accu_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after last+1, wrapping; idle when en is low.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    int unsigned k;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    if (en) begin
      for (int unsigned i = 1; i <= unsigned'(NREQ); i++) begin
        k = (32'(last) + i) % unsigned'(NREQ);
        if (!found && req[k]) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          idx    = IDXW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/accu_sched.sv
// Round-robin job scheduler sharing one clear/accumulate datapath among NREQ requesters.
module accu_sched
  import accu_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENW  = DEF_LENW
) (
  input  logic               clk,
  input  logic               reset,
  accu_sched_if.slave        rq,
  output logic               acc_clr,
  output logic [WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]   acc_out
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e    state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [WIDTH-1:0] result_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDXW-1:0] arb_idx;
  logic            arb_en;
  logic [NREQ-1:0] owner_oh;

  logic [NREQ-1:0] pop, gnt, done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req  (rq.req),
    .last (last_q),
    .en   (arb_en),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // last_q doubles as the owner index for the job in flight
  assign owner_oh = NREQ'(1) << last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= IDXW'(NREQ - 1);
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (state_q == ST_DRAIN) begin
        result_q <= acc_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    arb_en  = 1'b0;
    pop     = '0;
    gnt     = '0;
    done    = '0;
    acc_clr = 1'b0;
    acc_in  = '0;
    case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (|arb_gnt) begin
          last_d  = arb_idx;
          cnt_d   = rq.len[arb_idx*LENW +: LENW];
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        gnt     = owner_oh;
        acc_clr = 1'b1;
        state_d = (cnt_q == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        gnt = owner_oh;
        if (rq.opd_vld[last_q]) begin
          pop    = owner_oh;
          acc_in = rq.opd[last_q*WIDTH +: WIDTH];
          cnt_d  = cnt_q - LENW'(1);
          if (cnt_q == LENW'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        gnt     = owner_oh;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = owner_oh;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rq.pop    = pop;
  assign rq.gnt    = gnt;
  assign rq.done   = done;
  assign rq.result = result_q;
  assign rq.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accu_sched.sv
// Directed bench for accu_sched with a behavioural accumulator on the acc_* side.
module tb_accu_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
  localparam int LENW  = 4;

  logic             clk;
  logic             reset;
  logic             acc_clr;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] acc_out;

  int nchk;
  int npass;

  accu_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) rq ();

  accu_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk     (clk),
    .reset   (reset),
    .rq      (rq),
    .acc_clr (acc_clr),
    .acc_in  (acc_in),
    .acc_out (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) acc_out <= '0;
    else if (acc_clr) acc_out <= '0;
    else acc_out <= acc_out + acc_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One job from request sampling (cycle 0) to its done pulse; opd_vld low for cycles [sfrom, sfrom+slen).
  task automatic job(input logic [1:0] mask, input int w, input int n, input int base, input int step,
                     input int sfrom, input int slen, input int exp_done, input int exp_res);
    int k, pops, clrs, dcyc;
    logic [1:0] oh;
    oh = 2'(1 << w);
    k = 0; pops = 0; clrs = 0; dcyc = -1;
    @(negedge clk);
    rq.req = mask; rq.len = {2{LENW'(n)}}; rq.opd = '0; rq.opd_vld = '0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) rq.req = '0;
      rq.opd = {2{WIDTH'(base + k * step)}};
      rq.opd_vld = (c >= sfrom && c < sfrom + slen) ? 2'b00 : 2'b11;
      #1;
      if (c == 1) check("gnt_at_clear", 32'(rq.gnt), 32'(oh));
      if (acc_clr) clrs++;
      if (rq.pop != '0) begin
        check("pop_owner", 32'(rq.pop), 32'(oh));
        check("acc_in_opd", 32'(acc_in), 32'(WIDTH'(base + k * step)));
        pops++; k++;
      end
      if (!rq.opd_vld[w]) begin
        check("stall_pop", 32'(rq.pop), 0);
        check("stall_acc_in", 32'(acc_in), 0);
      end
      if (rq.done != '0) begin
        dcyc = c;
        check("done_owner", 32'(rq.done), 32'(oh));
        check("result", 32'(rq.result), 32'(exp_res));
      end
    end
    check("done_cycle", 32'(dcyc), 32'(exp_done));
    check("pop_count", 32'(pops), 32'(n));
    check("clr_cycles", 32'(clrs), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(rq.gnt), 0);
    check({tag, "_pop"}, 32'(rq.pop), 0);
    check({tag, "_done"}, 32'(rq.done), 0);
    check({tag, "_result"}, 32'(rq.result), 0);
    check({tag, "_busy"}, 32'(rq.busy), 0);
    check({tag, "_acc_clr"}, 32'(acc_clr), 0);
    check({tag, "_acc_in"}, 32'(acc_in), 0);
  endtask

  initial begin
    int nd, ndone;
    nchk = 0; npass = 0;
    rq.req = '0; rq.len = '0; rq.opd = '0; rq.opd_vld = '0;
    reset = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b0;

    job(2'b01, 0, 3, 1, 1, 0, 0, 6, 6);
    job(2'b10, 1, 4, 2, 0, 3, 2, 9, 8);
    job(2'b01, 0, 0, 0, 0, 0, 0, 3, 0);
    job(2'b01, 0, 4, 100, 0, 0, 0, 7, 144);

    // Both requesters continuously active: grants must alternate from a fresh pointer.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    rq.req = 2'b11; rq.len = {LENW'(1), LENW'(1)}; rq.opd = {WIDTH'(7), WIDTH'(5)}; rq.opd_vld = 2'b11;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      @(negedge clk); #1;
      if (rq.done != '0) begin
        check("alt_owner", 32'(rq.done), 32'(1 << (ndone % 2)));
        check("alt_result", 32'(rq.result), (ndone % 2 == 0) ? 5 : 7);
        ndone++;
      end
    end
    check("alt_done_count", 32'(ndone), 4);
    @(negedge clk); rq.req = '0;

    // Abort a len=5 job from requester 0 mid-RUN, then both request: 0 must win again.
    @(negedge clk);
    rq.req = 2'b01; rq.len = {2{LENW'(5)}}; rq.opd = {2{WIDTH'(9)}}; rq.opd_vld = 2'b11;
    @(negedge clk); rq.req = '0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(rq.busy), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge clk); reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (rq.done != '0) nd++;
    end
    check("abort_no_done", 32'(nd), 0);
    job(2'b11, 0, 2, 3, 1, 0, 0, 5, 7);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
